// File: rtl/wb_pkg.sv
// Shared encodings for the writeback/commit stage: FSM states, data-source and load-size codes.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wb_state_t;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    localparam logic [1:0] LD_WORD = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_BYTE = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Per-instruction control captured on accept.
    typedef struct packed {
        logic       regwre;
        logic [4:0] rd;
    } wb_ctl_t;

endpackage

// File: rtl/wb_load_align.sv
// Load lane extraction and sign/zero extension for sub-word loads (used under WB_BYTE_LOAD_EN).
module wb_load_align
    import wb_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    offset,
    input  logic [1:0]    size,
    input  logic          sign,
    output logic [DW-1:0] data_c,
    output logic          misaligned_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{offset, 3'b000} +: 8];
    assign half_lane = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        data_c       = rdata;
        misaligned_c = 1'b0;
        case (size)
            LD_BYTE: data_c = {{(DW-8){sign & byte_lane[7]}}, byte_lane};
            LD_HALF: begin
                data_c       = {{(DW-16){sign & half_lane[15]}}, half_lane};
                misaligned_c = offset[0];
            end
            default: misaligned_c = (offset != 2'b00);
        endcase
    end

endmodule

// File: rtl/wb_result_commit.sv
// Register-writeback commit: selects ALU or load data, waits (bounded) for memory, pulses the RF write.
// Optional sub-word load support is enabled with `define WB_BYTE_LOAD_EN.
module wb_result_commit
    import wb_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned DW          = 32
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          DBDataSrc,
    input  logic          RegWre,
    input  logic [4:0]    rd,
    input  logic [DW-1:0] alu_result,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
`ifdef WB_BYTE_LOAD_EN
    input  logic [1:0]    ld_size,
    input  logic [0:0]    ld_sign,
`endif
    output logic          wb_we,
    output logic [4:0]    wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          stall,
    output logic          fwd_valid,
    output logic [4:0]    fwd_addr,
    output logic [DW-1:0] fwd_data,
    output logic          mem_err
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    wb_state_t     state_q, state_d;
    wb_ctl_t       ctl_q, ctl_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_d;
    logic          accept_c;
    logic          we_d;
    logic          fwd_pend_d;
    logic [DW-1:0] load_data_c;
    logic          load_bad_c;

`ifdef WB_BYTE_LOAD_EN
    logic [1:0] size_q, size_d;
    logic       sign_q, sign_d;

    // data_q still holds the load address while waiting, so its low bits give the lane offset.
    wb_load_align #(.DW(DW)) u_align (
        .rdata        (mem_rdata),
        .offset       (data_q[1:0]),
        .size         (size_q),
        .sign         (sign_q),
        .data_c       (load_data_c),
        .misaligned_c (load_bad_c)
    );
`else
    assign load_data_c = mem_rdata;
    assign load_bad_c  = 1'b0;
`endif

    assign accept_c = in_valid & in_ready;
    assign stall    = in_valid & ~in_ready;

    // Next-state, capture and output decode.
    always_comb begin
        state_d = state_q;
        ctl_d   = ctl_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = mem_err;
`ifdef WB_BYTE_LOAD_EN
        size_d  = size_q;
        sign_d  = sign_q;
`endif
        case (state_q)
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    if (load_bad_c) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        data_d  = load_data_c;
                        state_d = WRITE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                if (accept_c) begin
                    ctl_d.regwre = RegWre;
                    ctl_d.rd     = rd;
                    data_d       = alu_result;
                    cnt_d        = '0;
`ifdef WB_BYTE_LOAD_EN
                    size_d       = ld_size;
                    sign_d       = ld_sign[0];
`endif
                    state_d      = (DBDataSrc == SRC_MEM) ? WAIT_MEM : WRITE;
                end
            end
        endcase

        we_d       = (state_d == WRITE) && ctl_d.regwre && (ctl_d.rd != REG_ZERO);
        fwd_pend_d = (state_d == WAIT_MEM) && ctl_d.regwre && (ctl_d.rd != REG_ZERO);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= IDLE;
            ctl_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            wb_we     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
            mem_err   <= 1'b0;
`ifdef WB_BYTE_LOAD_EN
            size_q    <= '0;
            sign_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ctl_q     <= ctl_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            in_ready  <= (state_d != WAIT_MEM);
            wb_we     <= we_d;
            mem_err   <= err_d;
            fwd_valid <= we_d | fwd_pend_d;
            fwd_addr  <= ctl_d.rd;
            // Pending-load forward carries no usable data; consumers stall on it instead.
            fwd_data  <= (state_d == WRITE) ? data_d : '0;
            if (state_d == WRITE) begin
                wb_addr <= ctl_d.rd;
                wb_data <= data_d;
            end
`ifdef WB_BYTE_LOAD_EN
            size_q    <= size_d;
            sign_q    <= sign_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_result_commit.sv
// Directed self-checking bench for wb_result_commit (covers WB_BYTE_LOAD_EN when defined).
module tb_wb_result_commit;

    localparam int unsigned DW = 32;
    localparam int unsigned MEM_TIMEOUT = 16;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          in_valid;
    logic          in_ready;
    logic          DBDataSrc;
    logic          RegWre;
    logic [4:0]    rd;
    logic [DW-1:0] alu_result;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
`ifdef WB_BYTE_LOAD_EN
    logic [1:0]    ld_size;
    logic [0:0]    ld_sign;
`endif
    logic          wb_we;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          stall;
    logic          fwd_valid;
    logic [4:0]    fwd_addr;
    logic [DW-1:0] fwd_data;
    logic          mem_err;

    int checks = 0;
    int errors = 0;

    wb_result_commit #(.MEM_TIMEOUT(MEM_TIMEOUT), .DW(DW)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .DBDataSrc  (DBDataSrc),
        .RegWre     (RegWre),
        .rd         (rd),
        .alu_result (alu_result),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
`ifdef WB_BYTE_LOAD_EN
        .ld_size    (ld_size),
        .ld_sign    (ld_sign),
`endif
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .stall      (stall),
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
        .mem_err    (mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic src, input logic we, input logic [4:0] r, input logic [31:0] a);
        in_valid   = 1'b1;
        DBDataSrc  = src;
        RegWre     = we;
        rd         = r;
        alu_result = a;
    endtask

    initial begin
        logic seen_we;
        Reset      = 1'b1;
        in_valid   = 1'b0;
        DBDataSrc  = 1'b0;
        RegWre     = 1'b0;
        rd         = '0;
        alu_result = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
`ifdef WB_BYTE_LOAD_EN
        ld_size    = 2'b00;
        ld_sign    = 1'b0;
`endif
        tick();
        tick();
        Reset = 1'b0;

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // Single ALU op: one cycle to the write.
        issue(1'b0, 1'b1, 5'd5, 32'h0000_1234);
        tick();
        in_valid = 1'b0;
        chk("alu_we", 32'(wb_we), 32'd1);
        chk("alu_addr", 32'(wb_addr), 32'd5);
        chk("alu_data", wb_data, 32'h0000_1234);
        chk("alu_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("alu_fwd_data", fwd_data, 32'h0000_1234);
        tick();
        chk("alu_we_drop", 32'(wb_we), 32'd0);
        chk("alu_data_hold", wb_data, 32'h0000_1234);

        // Back-to-back ALU ops.
        for (int i = 1; i <= 4; i++) begin
            issue(1'b0, 1'b1, 5'(i), 32'h100 + 32'(i));
            tick();
            chk("b2b_we", 32'(wb_we), 32'd1);
            chk("b2b_addr", 32'(wb_addr), 32'(i));
            chk("b2b_data", wb_data, 32'h100 + 32'(i));
            chk("b2b_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_end_we", 32'(wb_we), 32'd0);

        // Load with data on the third wait cycle.
        issue(1'b1, 1'b1, 5'd8, 32'h0000_0100);
        tick();
        issue(1'b0, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk("ld_ready", 32'(in_ready), 32'd0);
            chk("ld_stall", 32'(stall), 32'd1);
            chk("ld_we", 32'(wb_we), 32'd0);
            chk("ld_fwd_valid", 32'(fwd_valid), 32'd1);
            chk("ld_fwd_addr", 32'(fwd_addr), 32'd8);
            if (k == 2) begin
                in_valid   = 1'b0;
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEAD_BEEF;
            end
            tick();
        end
        mem_rvalid = 1'b0;
        chk("ld_wr_we", 32'(wb_we), 32'd1);
        chk("ld_wr_addr", 32'(wb_addr), 32'd8);
        chk("ld_wr_data", wb_data, 32'hDEAD_BEEF);
        chk("ld_wr_ready", 32'(in_ready), 32'd1);
        tick();

        // Register zero is never written.
        issue(1'b0, 1'b1, 5'd0, 32'h0000_0055);
        tick();
        in_valid = 1'b0;
        chk("r0_we", 32'(wb_we), 32'd0);
        chk("r0_addr", 32'(wb_addr), 32'd0);
        chk("r0_data", wb_data, 32'h0000_0055);
        chk("r0_fwd", 32'(fwd_valid), 32'd0);

        // mem_rvalid outside WAIT_MEM is ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        chk("idle_rvalid_we", 32'(wb_we), 32'd0);
        chk("idle_rvalid_data", wb_data, 32'h0000_0055);

        // Load timeout after MEM_TIMEOUT wait cycles.
        issue(1'b1, 1'b1, 5'd9, 32'h0000_0200);
        tick();
        in_valid = 1'b0;
        seen_we  = 1'b0;
        for (int k = 1; k < MEM_TIMEOUT; k++) begin
            tick();
            seen_we = seen_we | wb_we;
        end
        chk("to_still_wait", 32'(in_ready), 32'd0);
        chk("to_no_err_yet", 32'(mem_err), 32'd0);
        tick();
        seen_we = seen_we | wb_we;
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_ready", 32'(in_ready), 32'd1);
        chk("to_no_we", 32'(seen_we), 32'd0);
        issue(1'b0, 1'b1, 5'd3, 32'h0000_0077);
        tick();
        in_valid = 1'b0;
        chk("to_alu_we", 32'(wb_we), 32'd1);
        chk("to_err_sticky", 32'(mem_err), 32'd1);
        tick();

        // Reset during WAIT_MEM abandons the load.
        issue(1'b1, 1'b1, 5'd10, 32'h0000_0300);
        tick();
        in_valid = 1'b0;
        chk("rw_wait", 32'(in_ready), 32'd0);
        Reset = 1'b1;
        tick();
        Reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk("rw_we", 32'(wb_we), 32'd0);
        chk("rw_ready", 32'(in_ready), 32'd1);
        chk("rw_err_clr", 32'(mem_err), 32'd0);
        chk("rw_data", wb_data, 32'd0);
        tick();
        chk("rw_we_late", 32'(wb_we), 32'd0);

`ifdef WB_BYTE_LOAD_EN
        // Signed byte load from lane 3.
        issue(1'b1, 1'b1, 5'd11, 32'h0000_0403);
        ld_size = 2'b10;
        ld_sign = 1'b1;
        tick();
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8012_3456;
        tick();
        mem_rvalid = 1'b0;
        chk("bl_we", 32'(wb_we), 32'd1);
        chk("bl_data", wb_data, 32'hFFFF_FF80);
        tick();

        // Unsigned half from upper lane.
        issue(1'b1, 1'b1, 5'd12, 32'h0000_0402);
        ld_size = 2'b01;
        ld_sign = 1'b0;
        tick();
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h9ABC_1234;
        tick();
        mem_rvalid = 1'b0;
        chk("hl_data", wb_data, 32'h0000_9ABC);
        tick();

        // Misaligned half: error, no write.
        issue(1'b1, 1'b1, 5'd13, 32'h0000_0401);
        ld_size = 2'b01;
        tick();
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        chk("mis_we", 32'(wb_we), 32'd0);
        chk("mis_err", 32'(mem_err), 32'd1);
        ld_size = 2'b00;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
